// File: rtl/mig_seq_eval.sv
// Programmable majority-inverter-graph evaluator: one MAJ node per clock.
// Ports: clk/rst, prog_* table write, node_cnt/out_inv/in_vec/start run, busy/done/result/err status.
module mig_seq_eval #(
  parameter int NIN    = 7,
  parameter int NNODES = 8,
  parameter int IDX_W  = $clog2(1 + NIN + NNODES),
  parameter int OP_W   = IDX_W + 1,
  localparam int AW    = $clog2(NNODES),
  localparam int CW    = $clog2(NNODES + 1),
  localparam int SW    = 2 ** IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_we,
  input  logic [AW-1:0]     prog_addr,
  input  logic [3*OP_W-1:0] prog_data,
  input  logic [CW-1:0]     node_cnt,
  input  logic              out_inv,
  input  logic [NIN-1:0]    in_vec,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              result,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  state_t state, state_nx;

  logic [3*OP_W-1:0] tbl [NNODES];
  logic [NIN-1:0]    vec;
  logic [NNODES-1:0] nodes;
  logic [CW-1:0]     len;
  logic [CW-1:0]     clamped;
  logic [AW-1:0]     p;
  logic              oinv;
  logic              accept;
  logic              zero_len;
  logic              last;
  logic [3*OP_W-1:0] cur;
  logic [IDX_W-1:0]  ix [3];
  logic [2:0]        inv_b;
  logic [2:0]        opv;
  logic [2:0]        bad;
  logic              maj;
  logic [SW-1:0]     src;

  assign busy     = (state == EVAL);
  assign done     = (state == DONE);
  assign accept   = start && (state != EVAL);
  assign clamped  = (node_cnt > CW'(NNODES)) ? CW'(NNODES) : node_cnt;
  assign zero_len = (clamped == '0);
  assign last     = (CW'(p) == len - CW'(1));
  assign cur      = tbl[p];

  // Flat index space: bit 0 is constant 0, then inputs, then node values.
  assign src = SW'({nodes, vec, 1'b0});

  for (genvar k = 0; k < 3; k++) begin : g_op
    assign ix[k]    = cur[(2-k)*OP_W +: IDX_W];
    assign inv_b[k] = cur[(2-k)*OP_W + IDX_W];
  end

  // Only nodes already evaluated in this run (n < p) may be read;
  // anything else reads as 0 and flags the run.
  always_comb begin
    opv = '0;
    bad = '0;
    for (int k = 0; k < 3; k++) begin
      if (int'(ix[k]) <= NIN + int'(p) &&
          int'(ix[k]) <= NIN + NNODES)
        opv[k] = src[ix[k]] ^ inv_b[k];
      else
        bad[k] = 1'b1;
    end
  end

  assign maj = (opv[0] & opv[1]) |
               (opv[0] & opv[2]) |
               (opv[1] & opv[2]);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = zero_len ? DONE : EVAL;
      EVAL: if (last) state_nx = DONE;
      DONE: begin
        if (start) state_nx = zero_len ? DONE : EVAL;
        else       state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Node table has no reset; writes are locked out only while evaluating.
  always_ff @(posedge clk) begin
    if (prog_we && !busy) tbl[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      vec    <= '0;
      nodes  <= '0;
      len    <= '0;
      p      <= '0;
      oinv   <= 1'b0;
      err    <= 1'b0;
      result <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        vec    <= in_vec;
        len    <= clamped;
        oinv   <= out_inv;
        nodes  <= '0;
        p      <= '0;
        err    <= zero_len;
        result <= 1'b0;
      end else if (state == EVAL) begin
        nodes[p] <= maj;
        if (|bad) err <= 1'b1;
        if (last) result <= maj ^ oinv;
        else      p <= p + 1'b1;
      end
    end
  end

endmodule

// File: doc/mig_seq_eval.md
# mig_seq_eval

Sequential, programmable majority-inverter-graph evaluator for the input-classification flow. It generalises our fixed, hand-wired majority-of-3 networks into a runtime-loaded node table of up to NNODES three-input majority nodes over an NIN-bit input vector. The block evaluates one node per clock and returns the last node's value through a start/done handshake. It sits beside the fixed networks as a reconfigurable checker and classifier: a new function is a table reload, not a re-synthesis.

## Interface
- NIN, 7, width of the input vector
- NNODES, 8, node table depth (maximum program length)
- IDX_W, $clog2(1+NIN+NNODES), operand index width
- OP_W, IDX_W+1, operand field width: {inv, idx}

- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- prog_we  in  1  node table write strobe
- prog_addr  in  $clog2(NNODES)  node index to write
- prog_data  in  3*OP_W  {a, b, c} operands, a in MSBs
- node_cnt  in  $clog2(NNODES+1)  program length L, sampled on accepted start
- out_inv  in  1  complement final result, sampled on accepted start
- in_vec  in  NIN  input vector, sampled on accepted start
- start  in  1  request evaluation
- busy  out  1  evaluation in progress
- done  out  1  one-cycle pulse: result valid
- result  out  1  final value, held until next accepted start
- err  out  1  sticky per run: illegal operand reference or L=0

## Operation
- Index space: 0 = constant 0; 1..NIN = in_vec[i-1]; NIN+1+n = node n value. Operand value = selected bit XOR inv.
- Node n = MAJ(a, b, c) = ab | ac | bc.
- States: IDLE, EVAL, DONE.
- IDLE: start=1 is accepted. Latch in_vec, node_cnt, out_inv. Clear all node value registers and err. Node pointer p=0. Go to EVAL, or to DONE with err=1 and result=0 if L=0.
- EVAL: compute node p from the table and register it. If p=L-1, go to DONE; otherwise p++.
- DONE: done=1 for this cycle. result = node[L-1] XOR out_inv. Return to IDLE. A start in this cycle is accepted exactly as in IDLE.
- Illegal operand: a node reference with index ≥ current p, a node ≥ L, or idx > NIN+NNODES. It reads 0 and sets err. err holds until the next accepted start.
- start while busy=1: ignored, no effect on the current run.
- Table writes: accepted when busy=0, including the DONE cycle. Ignored while busy=1. The table is not cleared by rst; contents after power-up are undefined.
- L > NNODES: clamped to NNODES.

## Timing
- Reset values: busy=0, done=0, result=0, err=0, state=IDLE. rst mid-run aborts immediately, and no done is issued.
- start accepted at edge of cycle 0. busy=1 in cycles 1..L. Nodes 0..L-1 evaluate in cycles 1..L. done=1 in cycle L+1 with busy=0. Latency = L+1 cycles.
- L=0: done in cycle 1, err=1, result=0.
- Back-to-back: a start in the done cycle gives busy=1 in the next cycle. Throughput is one run per L+1 cycles.
- A table write in the same cycle as an accepted start is visible to that run.
- result and err are stable from done until the next accepted start.

## Test plan
- Program 6 nodes using inputs x0..x6 (index i+1), node indices 8..13:
  - n0=M(x1,x2,x5), n1=M(x3,x4,x5), n2=M(x1,x2,x6), n3=M(x3,x4,x6), n4=M(x0,n0,n3), n5=M(n1,n2,n4); L=6, out_inv=0.
  - in_vec with x1=x2=x3=x4=1, others 0 -> done at cycle 7, result=1, err=0.
  - in_vec=0 -> result=0.
- Same program, out_inv=1, in_vec=0 -> result=1. Also set the inv bit on operand a of n5 and compare against a reference model over all 128 inputs.
- n0 operand referencing node index 9 (itself+1, forward) -> err=1, operand reads 0; the next clean run clears err.
- L=0 -> done in cycle 1, result=0, err=1. node_cnt=NNODES+1 (clamped) -> done at cycle NNODES+1.
- start asserted every cycle during a run, plus prog_we during busy -> single done; table unchanged, verified by a rerun.
- rst asserted at cycle 3 of an L=6 run -> no done pulse, all outputs 0 next cycle; a new start completes normally.
